fp32_to_int_converter: RTL and testbench

FP32_TO_INT_CONVERTER -- requirements
Module: fp32_to_int_converter

---
 rtl/fp32_to_int_converter.sv | 210 +++++++++++++++++++++
 tb/tb_fp32_to_int_converter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_to_int_converter.sv
// fp32_to_int_converter
//   Two-stage pipelined IEEE-754 binary32 to int32/uint32 converter.
//   Stage 1 decodes the operand and aligns the significand to the integer
//   position (integer part + guard + sticky). Stage 2 rounds, negates,
//   saturates and generates the exception flags.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   stall      : hold every pipeline register
//   clear      : flush, zeroes both valid bits (wins over stall)
//   in_valid   : lhs carries an operand this cycle
//   lhs        : binary32 operand
//   is_signed  : 1 = int32 result, 0 = uint32 result
//   round_mode : 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM (others = RNE)
//   out_valid  : result / fflags valid
//   result     : converted integer
//   fflags     : {NV, DZ, OF, UF, NX}
module fp32_to_int_converter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [31:0] lhs,
  input  logic        is_signed,
  input  logic [2:0]  round_mode,
  output logic        out_valid,
  output logic [31:0] result,
  output logic [4:0]  fflags
);

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_SUB,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_class_e;

  // ---------------------------------------------------------------- stage 1
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [22:0] in_frac;
  logic [5:0]  align_shamt;
  logic [55:0] aligned;

  fp_class_e   cls_next;
  logic [31:0] int_next;
  logic        guard_next;
  logic        sticky_next;
  logic        big_next;

  assign in_sign = lhs[31];
  assign in_exp  = lhs[30:23];
  assign in_frac = lhs[22:0];

  // Fixed point word: bits [55:24] integer part, [23:0] fraction. The hidden
  // bit lands at position e+24, so shifting {1,frac} left by e+1 aligns it.
  // Only exponents 126..158 (e = -1..31) use this path, giving shifts 0..32.
  assign align_shamt = 6'(in_exp - 8'd126);
  assign aligned     = {32'd0, 1'b1, in_frac} << align_shamt;

  always_comb begin
    cls_next    = CLS_NORM;
    int_next    = 32'd0;
    guard_next  = 1'b0;
    sticky_next = 1'b0;
    big_next    = 1'b0;

    if (in_exp == 8'd0)
      cls_next = (in_frac == 23'd0) ? CLS_ZERO : CLS_SUB;
    else if (in_exp == 8'hFF)
      cls_next = (in_frac == 23'd0) ? CLS_INF : CLS_NAN;

    if (cls_next == CLS_NORM) begin
      if (in_exp >= 8'd159) begin
        // |value| >= 2^32: out of range for both result types, no rounding
        // can bring it back.
        big_next = 1'b1;
      end else if (in_exp >= 8'd126) begin
        int_next    = aligned[55:24];
        guard_next  = aligned[23];
        sticky_next = |aligned[22:0];
      end else begin
        // |value| < 0.5: nothing reaches the guard position.
        sticky_next = 1'b1;
      end
    end else if (cls_next == CLS_SUB) begin
      sticky_next = 1'b1;
    end
  end

  logic        s1_valid_reg;
  logic        s1_sign_reg;
  fp_class_e   s1_cls_reg;
  logic [31:0] s1_int_reg;
  logic        s1_guard_reg;
  logic        s1_sticky_reg;
  logic        s1_big_reg;
  logic        s1_signed_reg;
  logic [2:0]  s1_rm_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg  <= 1'b0;
      s1_sign_reg   <= 1'b0;
      s1_cls_reg    <= CLS_ZERO;
      s1_int_reg    <= 32'd0;
      s1_guard_reg  <= 1'b0;
      s1_sticky_reg <= 1'b0;
      s1_big_reg    <= 1'b0;
      s1_signed_reg <= 1'b0;
      s1_rm_reg     <= 3'd0;
    end else if (clear) begin
      s1_valid_reg <= 1'b0;
    end else if (!stall) begin
      s1_valid_reg  <= in_valid;
      s1_sign_reg   <= in_sign;
      s1_cls_reg    <= cls_next;
      s1_int_reg    <= int_next;
      s1_guard_reg  <= guard_next;
      s1_sticky_reg <= sticky_next;
      s1_big_reg    <= big_next;
      s1_signed_reg <= is_signed;
      s1_rm_reg     <= round_mode;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic        inexact;
  logic        round_inc;
  logic [32:0] mag;
  logic [32:0] neg_mag;
  logic [32:0] pos_limit;
  logic [32:0] neg_limit;
  logic [31:0] pos_sat;
  logic [31:0] neg_sat;
  logic        nv_next;
  logic [31:0] result_next;
  logic [4:0]  fflags_next;

  assign inexact = s1_guard_reg | s1_sticky_reg;

  always_comb begin
    case (s1_rm_reg)
      3'b001:  round_inc = 1'b0;
      3'b010:  round_inc = s1_sign_reg & inexact;
      3'b011:  round_inc = ~s1_sign_reg & inexact;
      3'b100:  round_inc = s1_guard_reg;
      default: round_inc = s1_guard_reg & (s1_sticky_reg | s1_int_reg[0]);
    endcase
  end

  // One spare bit so a rounded magnitude of 2^32 cannot wrap.
  assign mag     = {1'b0, s1_int_reg} + {32'd0, round_inc};
  assign neg_mag = 33'd0 - mag;

  // Largest representable magnitude in each direction, and the matching
  // saturation value.
  assign pos_limit = s1_signed_reg ? 33'h0_7FFF_FFFF : 33'h0_FFFF_FFFF;
  assign neg_limit = s1_signed_reg ? 33'h0_8000_0000 : 33'h0_0000_0000;
  assign pos_sat   = s1_signed_reg ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
  assign neg_sat   = s1_signed_reg ? 32'h8000_0000 : 32'h0000_0000;

  always_comb begin
    nv_next     = 1'b0;
    result_next = 32'd0;
    if (s1_cls_reg == CLS_NAN) begin
      nv_next     = 1'b1;
      result_next = pos_sat;
    end else if (s1_cls_reg == CLS_INF || s1_big_reg) begin
      nv_next     = 1'b1;
      result_next = s1_sign_reg ? neg_sat : pos_sat;
    end else if (!s1_sign_reg && mag > pos_limit) begin
      nv_next     = 1'b1;
      result_next = pos_sat;
    end else if (s1_sign_reg && mag > neg_limit) begin
      nv_next     = 1'b1;
      result_next = neg_sat;
    end else begin
      // For unsigned negatives this branch is only reached with mag == 0.
      result_next = s1_sign_reg ? neg_mag[31:0] : mag[31:0];
    end
    fflags_next = {nv_next, 3'b000, ~nv_next & inexact};
  end

  logic        out_valid_reg;
  logic [31:0] result_reg;
  logic [4:0]  fflags_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      result_reg    <= 32'd0;
      fflags_reg    <= 5'd0;
    end else if (clear) begin
      out_valid_reg <= 1'b0;
    end else if (!stall) begin
      out_valid_reg <= s1_valid_reg;
      result_reg    <= result_next;
      fflags_reg    <= fflags_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign fflags    = fflags_reg;

endmodule

// File: tb/tb_fp32_to_int_converter.sv
module tb_fp32_to_int_converter;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        clear;
  logic        in_valid;
  logic [31:0] lhs;
  logic        is_signed;
  logic [2:0]  round_mode;
  logic        out_valid;
  logic [31:0] result;
  logic [4:0]  fflags;

  fp32_to_int_converter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .clear      (clear),
    .in_valid   (in_valid),
    .lhs        (lhs),
    .is_signed  (is_signed),
    .round_mode (round_mode),
    .out_valid  (out_valid),
    .result     (result),
    .fflags     (fflags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Reference: value = m * 2^p as an exact rational, rounded with a
  // quotient/remainder comparison against one half, then range-checked
  // as a plain 64-bit integer.
  function automatic void ref_model(input logic [31:0] x, input bit sgn, input logic [2:0] rm,
                                    output logic [31:0] res, output logic [4:0] fl);
    bit     neg;
    int     ex;
    int     p;
    longint m, q, r, den, mag, v, lo, hi;
    bit     inexact, inc, nv;
    neg = x[31];
    ex  = int'(x[30:23]);
    if (ex == 255 && x[22:0] != 23'd0) begin
      res = sgn ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
      fl  = 5'b10000;
      return;
    end
    if (ex == 255) begin
      m = longint'(1) << 23;
      p = 127;
    end else if (ex == 0) begin
      m = longint'(x[22:0]);
      p = -149;
    end else begin
      m = (longint'(1) << 23) + longint'(x[22:0]);
      p = ex - 150;
    end
    if (p >= 0) begin
      if (p > 20) p = 20;
      q = m << p;
      r = 0;
      den = 1;
    end else if (-p >= 40) begin
      q = 0;
      r = m;
      den = longint'(1) << 40;
    end else begin
      den = longint'(1) << (-p);
      q = m / den;
      r = m % den;
    end
    inexact = (r != 0);
    case (rm)
      3'd1:    inc = 1'b0;
      3'd2:    inc = neg && inexact;
      3'd3:    inc = !neg && inexact;
      3'd4:    inc = (2 * r >= den);
      default: inc = (2 * r > den) || ((2 * r == den) && (q % 2 == 1));
    endcase
    mag = q + (inc ? 1 : 0);
    v   = neg ? -mag : mag;
    lo  = sgn ? -(longint'(1) << 31) : 0;
    hi  = sgn ? (longint'(1) << 31) - 1 : (longint'(1) << 32) - 1;
    nv  = 1'b0;
    if (v > hi) begin
      res = hi[31:0];
      nv  = 1'b1;
    end else if (v < lo) begin
      res = lo[31:0];
      nv  = 1'b1;
    end else begin
      res = v[31:0];
    end
    fl = {nv, 3'b000, !nv && inexact};
  endfunction

  typedef struct packed {
    logic [31:0] lhs;
    logic        sgn;
    logic [2:0]  rm;
    logic [31:0] res;
    logic [4:0]  fl;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  // Scoreboard for the randomized stream.
  logic [36:0] exp_q [$];
  bit          mon_en = 1'b0;
  logic        last_stall = 1'b0;

  always @(posedge clk) last_stall <= stall;

  always @(negedge clk) begin
    if (mon_en && rst_n && !last_stall && out_valid) begin
      if (exp_q.size() == 0) begin
        check("rand_unexpected_out", {32'd0, out_valid}, 64'd0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("rand_result", {32'd0, result}, {32'd0, e[36:5]});
        check("rand_fflags", {59'd0, fflags}, {59'd0, e[4:0]});
      end
    end
  end

  initial begin
    logic [31:0] rx;
    logic [31:0] rres;
    logic [4:0]  rfl;
    bit          rs;
    logic [2:0]  rrm;
    int          waited;

    rst_n = 1'b0; stall = 1'b0; clear = 1'b0; in_valid = 1'b0;
    lhs = 32'd0; is_signed = 1'b0; round_mode = 3'd0;

    vecs[0]  = '{32'h3FC0_0000, 1'b1, 3'd0, 32'h0000_0002, 5'b00001};
    vecs[1]  = '{32'hC020_0000, 1'b1, 3'd0, 32'hFFFF_FFFE, 5'b00001};
    vecs[2]  = '{32'h3FC0_0000, 1'b1, 3'd1, 32'h0000_0001, 5'b00001};
    vecs[3]  = '{32'h3FC0_0000, 1'b1, 3'd2, 32'h0000_0001, 5'b00001};
    vecs[4]  = '{32'h3FC0_0000, 1'b1, 3'd3, 32'h0000_0002, 5'b00001};
    vecs[5]  = '{32'hC020_0000, 1'b1, 3'd4, 32'hFFFF_FFFD, 5'b00001};
    vecs[6]  = '{32'h4F00_0000, 1'b1, 3'd0, 32'h7FFF_FFFF, 5'b10000};
    vecs[7]  = '{32'h4F00_0000, 1'b0, 3'd0, 32'h8000_0000, 5'b00000};
    vecs[8]  = '{32'hCF00_0000, 1'b1, 3'd0, 32'h8000_0000, 5'b00000};
    vecs[9]  = '{32'h7FC0_0000, 1'b0, 3'd0, 32'hFFFF_FFFF, 5'b10000};
    vecs[10] = '{32'hBF80_0000, 1'b0, 3'd0, 32'h0000_0000, 5'b10000};
    vecs[11] = '{32'hBE99_999A, 1'b0, 3'd1, 32'h0000_0000, 5'b00001};
    vecs[12] = '{32'hFF80_0000, 1'b1, 3'd0, 32'h8000_0000, 5'b10000};
    vecs[13] = '{32'h3FC0_0000, 1'b1, 3'd7, 32'h0000_0002, 5'b00001};
    vecs[14] = '{32'h0000_0001, 1'b1, 3'd0, 32'h0000_0000, 5'b00001};
    vecs[15] = '{32'h8000_0000, 1'b1, 3'd0, 32'h0000_0000, 5'b00000};
    vecs[16] = '{32'h4F80_0000, 1'b0, 3'd0, 32'hFFFF_FFFF, 5'b10000};
    vecs[17] = '{32'h4F7F_FFFF, 1'b0, 3'd0, 32'hFFFF_FF00, 5'b00000};
    vecs[18] = '{32'h3F00_0000, 1'b1, 3'd0, 32'h0000_0000, 5'b00001};
    vecs[19] = '{32'h7F80_0000, 1'b1, 3'd0, 32'h7FFF_FFFF, 5'b10000};

    // Reset state, with the clock running and an operand offered.
    in_valid = 1'b1; lhs = 32'h4120_0000; is_signed = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_valid",  {63'd0, out_valid}, 64'd0);
    check("reset_result", {32'd0, result},    64'd0);
    check("reset_fflags", {59'd0, fflags},    64'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Directed table, one operand at a time.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      in_valid = 1'b1; lhs = vecs[i].lhs; is_signed = vecs[i].sgn; round_mode = vecs[i].rm;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      $display("vec %0d lhs=%h signed=%0d rm=%0d -> result=%h fflags=%b",
               i, vecs[i].lhs, vecs[i].sgn, vecs[i].rm, result, fflags);
      check($sformatf("vec%0d_valid", i),  {63'd0, out_valid}, 64'd1);
      check($sformatf("vec%0d_result", i), {32'd0, result},    {32'd0, vecs[i].res});
      check($sformatf("vec%0d_fflags", i), {59'd0, fflags},    {59'd0, vecs[i].fl});
    end

    // Pipeline control: three back-to-back operands, stall, clear under stall.
    @(negedge clk);
    in_valid = 1'b1; lhs = 32'h3F80_0000; is_signed = 1'b1; round_mode = 3'd0;  // 1.0
    @(negedge clk);
    lhs = 32'h4000_0000;                                                          // 2.0
    @(negedge clk);
    check("pc_a_valid",  {63'd0, out_valid}, 64'd1);
    check("pc_a_result", {32'd0, result},    64'd1);
    lhs = 32'h4040_0000;                                                          // 3.0
    @(negedge clk);
    check("pc_b_result", {32'd0, result}, 64'd2);
    in_valid = 1'b0; stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      $display("stall cycle %0d out_valid=%0d result=%h", k, out_valid, result);
      check("pc_hold_valid",  {63'd0, out_valid}, 64'd1);
      check("pc_hold_result", {32'd0, result},    64'd2);
    end
    clear = 1'b1;
    @(negedge clk);
    check("pc_clear_valid", {63'd0, out_valid}, 64'd0);
    clear = 1'b0; stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("pc_flushed_valid", {63'd0, out_valid}, 64'd0);
    end

    // Reset while operands are in flight.
    in_valid = 1'b1; lhs = 32'h4040_0000; is_signed = 1'b1; round_mode = 3'd0;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_pre_valid", {63'd0, out_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid",  {63'd0, out_valid}, 64'd0);
    check("rst_async_result", {32'd0, result},    64'd0);
    check("rst_async_fflags", {59'd0, fflags},    64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; lhs = 32'h4120_0000; is_signed = 1'b1; round_mode = 3'd0;
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_after_bubble", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    $display("post-reset 10.0 -> valid=%0d result=%h fflags=%b", out_valid, result, fflags);
    check("rst_after_valid",  {63'd0, out_valid}, 64'd1);
    check("rst_after_result", {32'd0, result},    64'h0A);
    check("rst_after_fflags", {59'd0, fflags},    64'd0);

    // Randomized stream with random bubbles and stalls.
    @(negedge clk);
    mon_en = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 1) == 0)
        rx = $urandom();
      else
        rx = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 165)), 23'($urandom())};
      rs  = 1'($urandom_range(0, 1));
      rrm = 3'($urandom_range(0, 7));
      lhs = rx; is_signed = rs; round_mode = rrm;
      in_valid = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 5) == 0);
      if (in_valid && !stall) begin
        ref_model(rx, rs, rrm, rres, rfl);
        exp_q.push_back({rres, rfl});
        $display("rand lhs=%h signed=%0d rm=%0d exp=%h/%b", rx, rs, rrm, rres, rfl);
      end
      @(negedge clk);
    end
    in_valid = 1'b0; stall = 1'b0;
    waited = 0;
    while (exp_q.size() != 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("rand_drain_empty", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
